// File: rtl/demorgan_pkg.sv
// ---------------------------------------------------------------------------
// demorgan_pkg
// Shared definitions for the De Morgan gate checker:
//   - bit positions of the eight gate-block outputs inside dut_out
//   - state encoding of the sequencer FSM
//   - number of input vectors walked per run
//   - helper that turns the settle parameter into a legal counter load
// ---------------------------------------------------------------------------
package demorgan_pkg;

   // Bit positions of each gate output inside the 8-bit dut_out bus
   localparam int NA_B     = 0;
   localparam int NB_B     = 1;
   localparam int NANDNB_B = 2;
   localparam int AANDB_B  = 3;
   localparam int NAANDB_B = 4;
   localparam int NAORNB_B = 5;
   localparam int AORB_B   = 6;
   localparam int NAORB_B  = 7;

   // Every {A,B} combination is exercised once per run
   localparam int NUM_VECTORS = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRIVE   = 3'd1,
      SETTLE  = 3'd2,
      SAMPLE  = 3'd3,
      DONE_ST = 3'd4
   } state_t;

   // A settle time of zero behaves like one cycle; anything above the
   // 4-bit counter range is clamped to its maximum.
   function automatic logic [3:0] settle_load(input int cycles);
      if (cycles < 1) begin
         return 4'd1;
      end else if (cycles > 15) begin
         return 4'd15;
      end else begin
         return 4'(cycles);
      end
   endfunction

endpackage

// File: rtl/demorgan_golden.sv
// ---------------------------------------------------------------------------
// demorgan_golden
// Purely combinational reference model of the De Morgan gate block.
// Ports:
//   a, b      : block inputs
//   expected  : golden value of the eight block outputs, bit order as in
//               demorgan_pkg (nA, nB, nAandnB, AandB, nAandB, nAornB,
//               AorB, nAorB from bit 0 upward)
// ---------------------------------------------------------------------------
module demorgan_golden
   import demorgan_pkg::*;
(
   input  logic       a,
   input  logic       b,
   output logic [7:0] expected
);

   // Reference truth table written with the textbook expressions so that
   // both forms of each De Morgan identity appear independently.
   always_comb begin
      expected           = '0;
      expected[NA_B]     = ~a;
      expected[NB_B]     = ~b;
      expected[NANDNB_B] = ~a & ~b;
      expected[AANDB_B]  = a & b;
      expected[NAANDB_B] = ~(a & b);
      expected[NAORNB_B] = ~a | ~b;
      expected[AORB_B]   = a | b;
      expected[NAORB_B]  = ~(a | b);
   end

endmodule

// File: rtl/demorgan_sequencer.sv
// ---------------------------------------------------------------------------
// demorgan_sequencer
// Clocked stimulus/check stage around the combinational De Morgan gate
// block. Walks {A,B} through 00,01,10,11, waits SETTLE_CYCLES after each
// drive, samples the block outputs, compares them to the golden table and
// checks both De Morgan identities. Results are sticky until the next start.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin a run (honoured only in IDLE or DONE_ST)
//   dut_out    : the block's eight outputs
//   a, b       : stimulus driven to the block
//   busy       : run in progress (DRIVE of vector 0 .. SAMPLE of vector 3)
//   done       : one-cycle pulse at the end of a run
//   pass       : last completed run had no mismatches and no identity error
//   vec_fail   : per-vector mismatch flags, bit i for {A,B}=i
//   bit_fail   : per-output sticky mismatch flags
//   ident_fail : [0] nAandnB!=nAorB seen, [1] nAornB!=nAandB seen
//   err_count  : number of failing vectors (0..4)
// ---------------------------------------------------------------------------
module demorgan_sequencer
   import demorgan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] dut_out,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] vec_fail,
   output logic [7:0] bit_fail,
   output logic [1:0] ident_fail,
   output logic [2:0] err_count
);

   localparam logic [3:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);
   localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);

   state_t     state;
   state_t     state_next;
   logic [1:0] idx;
   logic [1:0] idx_next;
   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic       a_next;
   logic       b_next;
   logic       done_next;
   logic       pass_next;
   logic [3:0] vec_fail_next;
   logic [7:0] bit_fail_next;
   logic [1:0] ident_fail_next;
   logic [2:0] err_count_next;

   logic [7:0] golden;
   logic [7:0] mism;
   logic [1:0] ident_mism;

   demorgan_golden u_golden (
      .a        (a),
      .b        (b),
      .expected (golden)
   );

   // Case inequality so that an X or Z on the block output is reported as
   // a mismatch instead of silently comparing equal.
   always_comb begin
      mism = '0;
      for (int i = 0; i < 8; i++) begin
         mism[i] = (dut_out[i] !== golden[i]);
      end
      ident_mism    = '0;
      ident_mism[0] = (dut_out[NANDNB_B] !== dut_out[NAORB_B]);
      ident_mism[1] = (dut_out[NAORNB_B] !== dut_out[NAANDB_B]);
   end

   // busy is decoded from the state so it covers exactly the active states
   assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);

   // State and result registers; reset aborts any run without a done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         a          <= 1'b0;
         b          <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         vec_fail   <= '0;
         bit_fail   <= '0;
         ident_fail <= '0;
         err_count  <= '0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         cnt        <= cnt_next;
         a          <= a_next;
         b          <= b_next;
         done       <= done_next;
         pass       <= pass_next;
         vec_fail   <= vec_fail_next;
         bit_fail   <= bit_fail_next;
         ident_fail <= ident_fail_next;
         err_count  <= err_count_next;
      end
   end

   // Next-state and result logic. Everything holds by default; done is the
   // only field that falls back to zero so it pulses for a single cycle.
   always_comb begin
      state_next      = state;
      idx_next        = idx;
      cnt_next        = cnt;
      a_next          = a;
      b_next          = b;
      done_next       = 1'b0;
      pass_next       = pass;
      vec_fail_next   = vec_fail;
      bit_fail_next   = bit_fail;
      ident_fail_next = ident_fail;
      err_count_next  = err_count;

      case (state)
         IDLE, DONE_ST: begin
            if (start) begin
               vec_fail_next   = '0;
               bit_fail_next   = '0;
               ident_fail_next = '0;
               err_count_next  = '0;
               pass_next       = 1'b0;
               idx_next        = '0;
               state_next      = DRIVE;
            end
         end

         DRIVE: begin
            a_next     = idx[1];
            b_next     = idx[0];
            cnt_next   = SETTLE_LOAD;
            state_next = SETTLE;
         end

         // The counter is loaded with N and the last settle cycle is the
         // one that sees it at 1, giving exactly N cycles here.
         SETTLE: begin
            cnt_next = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_next = SAMPLE;
            end
         end

         // pass is formed from the updated counts so the last vector's
         // result is included in the verdict.
         SAMPLE: begin
            bit_fail_next   = bit_fail | mism;
            ident_fail_next = ident_fail | ident_mism;
            if (mism != 8'h00) begin
               vec_fail_next[idx] = 1'b1;
               err_count_next     = err_count + 3'd1;
            end
            if (idx == LAST_IDX) begin
               done_next  = 1'b1;
               pass_next  = (err_count_next == 3'd0) && (ident_fail_next == 2'b00);
               state_next = DONE_ST;
            end else begin
               idx_next   = idx + 2'd1;
               state_next = DRIVE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
